seven_scan_ctrl: RTL and testbench
==================================

// Module: seven_scan_ctrl
// PURPOSE
// - Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
// - Shares one seven_display hex decoder across NUM_DIGITS digits by cycling the anode
//   strobes and steering the active digit's nibble into the decoder.
// - Buffers host writes and commits them only at a frame boundary, so no frame shows a
//   mix of old and new digits.
// - Sits between the lab top-level (counters/FSMs producing values) and the board pins.
// PARAMETERS
// - NUM_DIGITS  4      digits scanned; >=2
// - SCAN_DIV    50000  clk cycles per digit slot (blank + show)
// - BLANK_CYC   500    cycles at start of each slot with all anodes off (anti-ghost); must be < SCAN_DIV
// PORTS
// - clk         in   1               single system clock, rising edge
// - rst_n       in   1               synchronous, active-low reset
// - load        in   1               1-cycle write strobe
// - load_data   in   4*NUM_DIGITS    hex nibbles; [3:0] = digit 0 (rightmost)
// - blank_mask  in   NUM_DIGITS      1 = force digit off; sampled live each cycle
// - lz_en       in   1               1 = suppress leading zeros of committed value
// - busy        out  1               1 = a load is pending commit
// - an          out  NUM_DIGITS      anode enables, active-low (0 = digit on)
// - seg         out  7               segments {g..a}, active-low, from the decoder
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): fsm=S_BLANK, idx=0, cnt=0, disp=0, pend=0, busy=0, an=all 1,
//   seg=7'b1111111. A reset mid-slot or mid-frame discards the pending load.
// - Prescaler cnt counts 0..SCAN_DIV-1 per slot and wraps to 0 at slot end.
// - FSM S_BLANK: all anodes off; after BLANK_CYC cycles go to S_SHOW.
// - FSM S_SHOW: an[idx]=0 unless suppressed; at cnt==SCAN_DIV-1 go to S_BLANK.
//   On that transition idx advances, wrapping NUM_DIGITS-1 -> 0.
// - Frame commit: in the cycle idx wraps to 0, if busy then disp<=pend and busy<=0.
// - load: pend<=load_data and busy<=1. Repeated loads within a frame: last write wins.
// - load in the commit cycle: the old pend is committed and the new data becomes pend
//   (busy stays 1).
// - Suppression: digit i is dark in S_SHOW if blank_mask[i]=1, or if lz_en=1 and all
//   nibbles of disp at positions >= i are 0. Digit 0 is never zero-suppressed.
// - Datapath: dec_in = disp[4*idx +: 4] feeds the decoder. an and seg are registered,
//   one cycle after fsm/idx. seg=7'b1111111 whenever all anodes are off.
// - Display latency: a value loaded in frame k appears from frame k+1, digit 0 first.
// - Widths: cnt is $clog2(SCAN_DIV) bits; idx is $clog2(NUM_DIGITS) bits.
//   There is no arithmetic on the data; nibbles pass through unchanged.
// STRUCTURE
// - Shared package seg_pkg:
//   - FSM state typedef {S_BLANK, S_SHOW}
//   - SEG_OFF = 7'b1111111
//   - AN_OFF helper
// - One sub-module, instance u_dec, of the existing seven_display (4-bit -> 7-bit,
//   active-low). Decoder is combinational, so the output register sits after it.
// - Prescaler, FSM, pend/disp registers and suppression logic live inline.
// TESTING (SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=4)
// - Reset: rst_n=0 for 3 edges -> an=4'b1111, seg=7'b1111111, busy=0. After release,
//   an=4'b1110 exactly 6 cycles per slot, 2 dark cycles between slots, order 0,1,2,3,0.
// - Load: load 16'h1234 mid-frame -> busy=1 until idx wraps. Next frame: digit0
//   seg=7'b0011001 ('4'), digit3 seg=7'b1111001 ('1'). Current frame still shows 0000.
// - Double load: loads 16'hAAAA then 16'h00F0 in one frame -> only 00F0 is displayed;
//   digit1 seg=7'b0001110.
// - Load on commit edge: load 16'h5555 pending, then load 16'h9999 in the wrap cycle ->
//   this frame shows 5555 and busy=1; the next frame shows 9999 and busy=0.
// - Suppression: lz_en=1 with 16'h0005 -> only an[0] ever low, seg=7'b0010010. With
//   16'h0000 -> digit0 shows 7'b1000000. blank_mask=4'b0010 -> an[1] never low.
// - Mid-operation reset: assert rst_n=0 during S_SHOW of digit2 with busy=1 ->
//   next edge an=4'b1111, busy=0, and the display restarts at digit0 showing 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Holds the scan FSM states, the blank segment pattern and the per-digit anode helper.
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low anode level for one digit: low only when that digit is the lit one.
  function automatic logic an_level(input int digit, input int idx, input logic on);
    return !(on && (digit == idx));
  endfunction

endpackage

// File: rtl/seven_scan_ctrl_if.sv
// Host-side bus of the scan controller: write strobe, data, live display controls and board pins.
// The master drives the value and controls; the slave (controller) drives busy and the pins.
interface seven_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_en;
  logic                    busy;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;

  modport master (
    output load, load_data, blank_mask, lz_en,
    input  busy, an, seg
  );

  modport slave (
    input  load, load_data, blank_mask, lz_en,
    output busy, an, seg
  );
endinterface

// File: rtl/seven_display.sv
// Combinational hex to 7-segment decoder, segments {g..a}, active-low.
// Zero latency; no flow control.
module seven_display (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner; an/seg are registered one cycle after fsm/idx.
// Host loads are never refused: they park in pend (last write wins) and commit at the frame wrap.
module seven_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t           r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic                  w_slot_end;
  logic                  w_frame_wrap;

  logic [DW-1:0]         r_disp;
  logic [DW-1:0]         r_pend;
  logic                  r_busy;

  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_on;
  logic [NUM_DIGITS-1:0] w_an;
  logic [3:0]            w_dec_in;
  logic [6:0]            w_dec;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_frame_wrap = 1'b0;
    w_slot_end   = (r_cnt == CNT_LAST);
    w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CW'(1);
    case (r_state)
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (w_slot_end) begin
          w_state_nxt  = S_BLANK;
          w_frame_wrap = (r_idx == IDX_LAST);
          w_idx_nxt    = w_frame_wrap ? '0 : r_idx + IW'(1);
        end
      end
      default: w_state_nxt = S_BLANK;
    endcase
  end

  // A load landing on the wrap edge still commits the older pend; the new one waits a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_pend <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_frame_wrap && r_busy) begin
        r_disp <= r_pend;
        r_busy <= 1'b0;
      end
      if (bus.load) begin
        r_pend <= bus.load_data;
        r_busy <= 1'b1;
      end
    end
  end

  always_comb begin : p_lz
    logic w_zero_run;
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (r_disp[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run;
    end
  end

  assign w_dec_in = r_disp[4*r_idx +: 4];

  seven_display u_dec (
    .i_hex (w_dec_in),
    .o_seg (w_dec)
  );

  always_comb begin
    w_on = (r_state == S_SHOW) && !bus.blank_mask[r_idx] && !(bus.lz_en && w_lz[r_idx]);
    w_an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an[i] = an_level(i, 32'(r_idx), w_on);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an;
      r_seg <= w_on ? w_dec : SEG_OFF;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_seven_scan_ctrl.sv
// Directed bench for seven_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=4 (32-cycle frames).
// Sample j of a captured frame is taken at the negedge after edge 32F+1+j and shows scan position 32F+j.
module tb_seven_scan_ctrl;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * SD;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] H0  = 7'b1000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seven_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] cap_an   [FRAME];
  logic [6:0] cap_seg  [FRAME];
  logic       cap_busy [FRAME];

  task automatic wait_frame();
    int guard = 0;
    while ((cyc % FRAME) != 0 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Records one whole frame; optional load pulses land on edge 32F+2+j for j = j1/j2.
  task automatic capture(input int j1, input logic [15:0] d1, input int j2, input logic [15:0] d2);
    wait_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      cap_an[j]      = bus.an;
      cap_seg[j]     = bus.seg;
      cap_busy[j]    = bus.busy;
      bus.load       = (j == j1) || (j == j2);
      bus.load_data  = (j == j2) ? d2 : d1;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.load       = 1'b0;
    bus.load_data  = 16'h0000;
    bus.blank_mask = 4'b0000;
    bus.lz_en      = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.an !== 4'b1111) begin n_err++; $display("FAIL reset_an got %b exp %b", bus.an, 4'b1111); end
    n_vec++; if (bus.seg !== OFF) begin n_err++; $display("FAIL reset_seg got %b exp %b", bus.seg, OFF); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] es;
    for (int f = 0; f < 2; f++) begin
      capture(-1, 16'h0, -1, 16'h0);
      for (int j = 0; j < FRAME; j++) begin
        ea = ((j % SD) >= BC) ? ~(4'b0001 << (j / SD)) : 4'b1111;
        es = ((j % SD) >= BC) ? H0 : OFF;
        n_vec++; if (cap_an[j] !== ea) begin n_err++; $display("FAIL scan_an f%0d j%0d got %b exp %b", f, j, cap_an[j], ea); end
        n_vec++; if (cap_seg[j] !== es) begin n_err++; $display("FAIL scan_seg f%0d j%0d got %b exp %b", f, j, cap_seg[j], es); end
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] exp_seg [N];
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    capture(10, 16'h1234, -1, 16'h0);
    n_vec++; if (cap_busy[10] !== 1'b0) begin n_err++; $display("FAIL load_busy_pre got %b exp 0", cap_busy[10]); end
    n_vec++; if (cap_busy[11] !== 1'b1) begin n_err++; $display("FAIL load_busy_set got %b exp 1", cap_busy[11]); end
    n_vec++; if (cap_busy[30] !== 1'b1) begin n_err++; $display("FAIL load_busy_hold got %b exp 1", cap_busy[30]); end
    n_vec++; if (cap_busy[31] !== 1'b0) begin n_err++; $display("FAIL load_busy_clr got %b exp 0", cap_busy[31]); end
    n_vec++; if (cap_seg[4] !== H0) begin n_err++; $display("FAIL load_old_d0 got %b exp %b", cap_seg[4], H0); end
    n_vec++; if (cap_seg[28] !== H0) begin n_err++; $display("FAIL load_old_d3 got %b exp %b", cap_seg[28], H0); end
    capture(-1, 16'h0, -1, 16'h0);
    for (int d = 0; d < N; d++) begin
      n_vec++; if (cap_an[8*d+4] !== ~(4'b0001 << d)) begin n_err++; $display("FAIL load_an d%0d got %b", d, cap_an[8*d+4]); end
      n_vec++; if (cap_seg[8*d+4] !== exp_seg[d]) begin n_err++; $display("FAIL load_seg d%0d got %b exp %b", d, cap_seg[8*d+4], exp_seg[d]); end
    end
  endtask

  task automatic test_double_load();
    logic [6:0] exp_seg [N];
    exp_seg = '{H0, 7'b0001110, H0, H0};
    capture(5, 16'hAAAA, 15, 16'h00F0);
    n_vec++; if (cap_busy[31] !== 1'b0) begin n_err++; $display("FAIL dbl_busy got %b exp 0", cap_busy[31]); end
    capture(-1, 16'h0, -1, 16'h0);
    for (int d = 0; d < N; d++) begin
      n_vec++; if (cap_seg[8*d+5] !== exp_seg[d]) begin n_err++; $display("FAIL dbl_seg d%0d got %b exp %b", d, cap_seg[8*d+5], exp_seg[d]); end
    end
  endtask

  task automatic test_commit_edge();
    capture(5, 16'h5555, 30, 16'h9999);
    n_vec++; if (cap_busy[31] !== 1'b1) begin n_err++; $display("FAIL edge_busy_a got %b exp 1", cap_busy[31]); end
    capture(-1, 16'h0, -1, 16'h0);
    n_vec++; if (cap_busy[0] !== 1'b1) begin n_err++; $display("FAIL edge_busy_b0 got %b exp 1", cap_busy[0]); end
    n_vec++; if (cap_busy[31] !== 1'b0) begin n_err++; $display("FAIL edge_busy_b31 got %b exp 0", cap_busy[31]); end
    for (int d = 0; d < N; d++) begin
      n_vec++; if (cap_seg[8*d+3] !== 7'b0010010) begin n_err++; $display("FAIL edge_seg5 d%0d got %b exp 0010010", d, cap_seg[8*d+3]); end
    end
    capture(-1, 16'h0, -1, 16'h0);
    n_vec++; if (cap_busy[0] !== 1'b0) begin n_err++; $display("FAIL edge_busy_c got %b exp 0", cap_busy[0]); end
    for (int d = 0; d < N; d++) begin
      n_vec++; if (cap_seg[8*d+6] !== 7'b0010000) begin n_err++; $display("FAIL edge_seg9 d%0d got %b exp 0010000", d, cap_seg[8*d+6]); end
    end
  endtask

  task automatic test_suppress();
    logic [3:0] ea;
    logic [6:0] es;
    bus.lz_en = 1'b1;
    capture(5, 16'h0005, -1, 16'h0);
    capture(-1, 16'h0, -1, 16'h0);
    for (int j = 0; j < FRAME; j++) begin
      ea = (j < SD && (j % SD) >= BC) ? 4'b1110 : 4'b1111;
      es = (ea == 4'b1110) ? 7'b0010010 : OFF;
      n_vec++; if (cap_an[j] !== ea) begin n_err++; $display("FAIL lz5_an j%0d got %b exp %b", j, cap_an[j], ea); end
      n_vec++; if (cap_seg[j] !== es) begin n_err++; $display("FAIL lz5_seg j%0d got %b exp %b", j, cap_seg[j], es); end
    end
    capture(5, 16'h0000, -1, 16'h0);
    capture(-1, 16'h0, -1, 16'h0);
    n_vec++; if (cap_an[3] !== 4'b1110) begin n_err++; $display("FAIL lz0_an0 got %b exp 1110", cap_an[3]); end
    n_vec++; if (cap_seg[3] !== H0) begin n_err++; $display("FAIL lz0_seg0 got %b exp %b", cap_seg[3], H0); end
    n_vec++; if (cap_an[12] !== 4'b1111) begin n_err++; $display("FAIL lz0_an1 got %b exp 1111", cap_an[12]); end
    bus.lz_en      = 1'b0;
    bus.blank_mask = 4'b0010;
    capture(5, 16'h1234, -1, 16'h0);
    capture(-1, 16'h0, -1, 16'h0);
    for (int j = 0; j < FRAME; j++) begin
      n_vec++; if (cap_an[j][1] !== 1'b1) begin n_err++; $display("FAIL mask_an1 j%0d got %b", j, cap_an[j]); end
    end
    n_vec++; if (cap_seg[12] !== OFF) begin n_err++; $display("FAIL mask_seg1 got %b exp %b", cap_seg[12], OFF); end
    n_vec++; if (cap_an[20] !== 4'b1011) begin n_err++; $display("FAIL mask_an2 got %b exp 1011", cap_an[20]); end
    n_vec++; if (cap_seg[20] !== 7'b0100100) begin n_err++; $display("FAIL mask_seg2 got %b exp 0100100", cap_seg[20]); end
    bus.blank_mask = 4'b0000;
  endtask

  task automatic test_mid_reset();
    wait_frame();
    repeat (6) @(negedge clk);
    bus.load      = 1'b1;
    bus.load_data = 16'h7777;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (14) @(negedge clk);
    n_vec++; if (bus.an !== 4'b1011) begin n_err++; $display("FAIL mrst_pre_an got %b exp 1011", bus.an); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mrst_pre_busy got %b exp 1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.an !== 4'b1111) begin n_err++; $display("FAIL mrst_an got %b exp 1111", bus.an); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.seg !== OFF) begin n_err++; $display("FAIL mrst_seg got %b exp %b", bus.seg, OFF); end
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture(-1, 16'h0, -1, 16'h0);
      n_vec++; if (cap_an[2] !== 4'b1110) begin n_err++; $display("FAIL mrst_d0_an f%0d got %b exp 1110", f, cap_an[2]); end
      for (int d = 0; d < N; d++) begin
        n_vec++; if (cap_seg[8*d+4] !== H0) begin n_err++; $display("FAIL mrst_seg f%0d d%0d got %b exp %b", f, d, cap_seg[8*d+4], H0); end
      end
      n_vec++; if (cap_busy[31] !== 1'b0) begin n_err++; $display("FAIL mrst_busy f%0d got %b exp 0", f, cap_busy[31]); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_double_load();
    test_commit_edge();
    test_suppress();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
